// File: rtl/axi_lite_shared_mem.sv
// axi_lite_shared_mem: AXI4-Lite shared register-file memory, round-robin write/read arbitration.
// Define AXI_LITE_SHARED_MEM_STALL_INJECT_EN for LFSR-driven grant stalls.
module axi_lite_shared_mem #(
   parameter int          ADDR_W    = 12,
   parameter int          DEPTH     = 64,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready
);
   localparam int IW = ADDR_W - 2;
   localparam int MW = $clog2(DEPTH);
   localparam logic [IW:0] LIMIT = (IW+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, WR_RESP, RD_DATA} state_t;
   state_t state;
   logic last_wr;
   logic [31:0] mem [DEPTH];
   logic [IW-1:0] widx, ridx;
   logic wr_ok, rd_ok, go, wr_el, rd_el, grant_wr, grant_rd;
   assign widx  = s_axi_awaddr[ADDR_W-1:2];
   assign ridx  = s_axi_araddr[ADDR_W-1:2];
   assign wr_ok = {1'b0, widx} < LIMIT;
   assign rd_ok = {1'b0, ridx} < LIMIT;
`ifdef AXI_LITE_SHARED_MEM_STALL_INJECT_EN
   logic [15:0] lfsr;
   logic unused_bits;
   assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
   always_ff @(posedge clock or posedge reset)
      if (reset) lfsr <= LFSR_SEED;
      else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign go = ~lfsr[0];
`else
   logic unused_bits;
   assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], LFSR_SEED};
   assign go = 1'b1;
`endif
   // Tie-break favours the channel not served last; readies only depend on state and valids
   always_comb begin
      wr_el    = s_axi_awvalid && s_axi_wvalid;
      rd_el    = s_axi_arvalid;
      grant_wr = (state == IDLE) && go && wr_el && (!rd_el || !last_wr);
      grant_rd = (state == IDLE) && go && rd_el && (!wr_el || last_wr);
   end
   assign s_axi_awready = grant_wr;
   assign s_axi_wready  = grant_wr;
   assign s_axi_arready = grant_rd;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         last_wr      <= 1'b0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= 2'b00;
         s_axi_rvalid <= 1'b0;
         s_axi_rresp  <= 2'b00;
         s_axi_rdata  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_wr) begin
                  for (int k = 0; k < 4; k++)
                     if (wr_ok && s_axi_wstrb[k]) mem[widx[MW-1:0]][8*k +: 8] <= s_axi_wdata[8*k +: 8];
                  s_axi_bresp  <= wr_ok ? 2'b00 : 2'b10;
                  s_axi_bvalid <= 1'b1;
                  last_wr      <= 1'b1;
                  state        <= WR_RESP;
               end else if (grant_rd) begin
                  s_axi_rdata  <= rd_ok ? mem[ridx[MW-1:0]] : '0;
                  s_axi_rresp  <= rd_ok ? 2'b00 : 2'b10;
                  s_axi_rvalid <= 1'b1;
                  last_wr      <= 1'b0;
                  state        <= RD_DATA;
               end
            end
            WR_RESP: if (s_axi_bready) begin
               s_axi_bvalid <= 1'b0;
               state        <= IDLE;
            end
            RD_DATA: if (s_axi_rready) begin
               s_axi_rvalid <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_shared_mem.sv
// tb_axi_lite_shared_mem: directed checks of reset, strobes, arbitration, SLVERR, backpressure, reset mid-read.
module tb_axi_lite_shared_mem;
   logic        clock = 0, reset = 1;
   logic [11:0] awaddr = 0, araddr = 0;
   logic [31:0] wdata = 0;
   logic [3:0]  wstrb = 0;
   logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   int errors = 0, checks = 0;
   logic [31:0] d;
   logic [1:0]  r;

   axi_lite_shared_mem dut (
      .clock(clock), .reset(reset),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] dat, input logic [3:0] s, output logic [1:0] resp);
      int n = 0;
      awaddr = a; wdata = dat; wstrb = s; awvalid = 1; wvalid = 1;
      #1;
      while (!(awready && wready) && n < 20) begin step(); n++; end
      chk("wr_accept", {30'd0, awready, wready}, 32'd3);
      step();
      awvalid = 0; wvalid = 0;
      chk("wr_bvalid_lat", {31'd0, bvalid}, 32'd1);
      resp = bresp;
      bready = 1;
      step();
      bready = 0;
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] dat, output logic [1:0] resp);
      int n = 0;
      araddr = a; arvalid = 1;
      #1;
      while (!arready && n < 20) begin step(); n++; end
      chk("rd_accept", {31'd0, arready}, 32'd1);
      step();
      arvalid = 0;
      chk("rd_rvalid_lat", {31'd0, rvalid}, 32'd1);
      dat = rdata; resp = rresp;
      rready = 1;
      step();
      rready = 0;
   endtask

   initial begin
      #2;
      chk("rst_outs", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      step(); step();
      reset = 0;
      step();
      rd(12'h008, d, r);
      chk("rd_init_data", d, 32'h0);
      chk("rd_init_resp", {30'd0, r}, 32'd0);
      wr(12'h008, 32'hDEADBEEF, 4'hF, r);
      chk("wr_full_resp", {30'd0, r}, 32'd0);
      wr(12'h008, 32'h00000011, 4'b0001, r);
      chk("wr_byte_resp", {30'd0, r}, 32'd0);
      rd(12'h008, d, r);
      chk("rd_merged", d, 32'hDEADBE11);
      wr(12'h008, 32'h55555555, 4'h0, r);
      chk("wr_nostrb_resp", {30'd0, r}, 32'd0);
      rd(12'h00A, d, r);
      chk("rd_nostrb_unch", d, 32'hDEADBE11);
      // Contention: last served is READ here, so expect W, -, R, -, W, -, R, -
      awaddr = 12'h00C; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      araddr = 12'h008; arvalid = 1; bready = 1; rready = 1;
      #1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("arb_aw%0d", i), {31'd0, awready}, {31'd0, i % 4 == 0});
         chk($sformatf("arb_ar%0d", i), {31'd0, arready}, {31'd0, i % 4 == 2});
         if (i == 7) begin
            chk("arb_rdata", rdata, 32'hDEADBE11);
            awvalid = 0; wvalid = 0; arvalid = 0;
         end
         if (i < 7) step();
      end
      step();
      bready = 0; rready = 0;
      rd(12'h00C, d, r);
      chk("rd_arb_write", d, 32'h12345678);
      wr(12'h100, 32'hFFFFFFFF, 4'hF, r);
      chk("oor_bresp", {30'd0, r}, 32'd2);
      rd(12'h100, d, r);
      chk("oor_rdata", d, 32'h0);
      chk("oor_rresp", {30'd0, r}, 32'd2);
      rd(12'h000, d, r);
      chk("oor_word0", d, 32'h0);
      rd(12'h0FC, d, r);
      chk("oor_word63", d, 32'h0);
      rd(12'h008, d, r);
      chk("oor_word2", d, 32'hDEADBE11);
      // Response backpressure with a read pending
      awaddr = 12'h010; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      #1;
      chk("bp_aw", {31'd0, awready}, 32'd1);
      step();
      awvalid = 0; wvalid = 0; araddr = 12'h010; arvalid = 1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_bvalid%0d", i), {31'd0, bvalid}, 32'd1);
         chk($sformatf("bp_bresp%0d", i), {30'd0, bresp}, 32'd0);
         chk($sformatf("bp_readies%0d", i), {30'd0, awready, arready}, 32'd0);
         step();
      end
      bready = 1;
      #1;
      chk("bp_ar_indep", {31'd0, arready}, 32'd0);
      step();
      bready = 0;
      chk("bp_bvalid_clr", {31'd0, bvalid}, 32'd0);
      chk("bp_ar_next", {31'd0, arready}, 32'd1);
      step();
      arvalid = 0;
      chk("bp_rvalid", {31'd0, rvalid}, 32'd1);
      chk("bp_rdata", rdata, 32'hA5A5A5A5);
      // Reset while holding a read response
      #2;
      reset = 1;
      #1;
      chk("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
      step(); step();
      reset = 0;
      step();
      rd(12'h010, d, r);
      chk("rst_mid_word4", d, 32'h0);
      rd(12'h008, d, r);
      chk("rst_mid_word2", d, 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axi_lite_shared_mem.md
Name: axi_lite_shared_mem

Overview:
- AXI4-Lite responder (slave) acting as the shared memory that the bakery-algorithm instances' AXI-Lite masters contend for: choosing/number arrays plus the shared counter word.
- Sits behind the interconnect at base 0xC000_1000.
- Single-ported register-file memory with round-robin arbitration between write and read channels.
- Byte-strobe writes, SLVERR on out-of-range access.

Parameters:
- ADDR_W, 12, byte-address width compared against memory window (window = 2^ADDR_W bytes)
- DEPTH, 64, number of 32-bit words implemented; word index >= DEPTH is out of range
- LFSR_SEED, 16'hACE1, seed for stall-injection LFSR (used only with optional feature)

Ports:
- clock  input  1  single clock for all logic
- reset  input  1  asynchronous, active-high reset
- s_axi_awaddr  input  ADDR_W  write address (byte)
- s_axi_awvalid  input  1  write address valid
- s_axi_awready  output  1  write address ready
- s_axi_wdata  input  32  write data
- s_axi_wstrb  input  4  byte strobes
- s_axi_wvalid  input  1  write data valid
- s_axi_wready  output  1  write data ready
- s_axi_bresp  output  2  write response (00 OKAY, 10 SLVERR)
- s_axi_bvalid  output  1  write response valid
- s_axi_bready  input  1  write response ready
- s_axi_araddr  input  ADDR_W  read address (byte)
- s_axi_arvalid  input  1  read address valid
- s_axi_arready  output  1  read address ready
- s_axi_rdata  output  32  read data
- s_axi_rresp  output  2  read response
- s_axi_rvalid  output  1  read data valid
- s_axi_rready  input  1  read data ready

Behaviour:
- Reset (async assert, sync deassert by upstream): all ready/valid outputs 0, bresp/rresp 00, rdata 0, all memory words 0, FSM IDLE, last_served = READ.
- FSM states: IDLE, WR_RESP, RD_DATA.
- IDLE:
  - Write is eligible when awvalid && wvalid (both required in the same cycle).
  - Read is eligible when arvalid.
  - If exactly one is eligible, serve it.
  - If both are eligible, serve the channel opposite to last_served.
  - Serving a write: awready = wready = 1 for that single cycle (combinational from IDLE & grant); memory updated at that edge; next state WR_RESP; last_served = WRITE.
  - Serving a read: arready = 1 for one cycle; rdata/rresp registered at that edge; next state RD_DATA; last_served = READ.
- WR_RESP: bvalid = 1 starting the cycle after acceptance. Held stable with bresp until bready; on bvalid && bready, return to IDLE. No new acceptance in this state.
- RD_DATA: rvalid = 1 the cycle after acceptance. rdata/rresp held stable until rready; on handshake, return to IDLE.
- Latency: address handshake to response valid = 1 cycle. Minimum back-to-back throughput = 1 transaction per 2 cycles, given ready tied high.
- Address decode: word index = addr[ADDR_W-1:2]; addr[1:0] ignored.
- Index >= DEPTH:
  - Write: discarded, bresp = SLVERR.
  - Read: rdata = 0, rresp = SLVERR.
- Byte strobes: byte k is written only if wstrb[k]. wstrb = 0 is a legal no-op with OKAY response.
- A read issued right after a write to the same word returns the new value; no forwarding hazard, since the write completes before the read is accepted.
- Reset mid-transaction: outstanding response dropped, memory cleared, FSM to IDLE.
- ready outputs never depend on bready/rready in the same cycle.

Optional Feature:
- Macro: AXI_LITE_SHARED_MEM_STALL_INJECT_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seeded LFSR_SEED at reset) advances every cycle.
  - When LFSR bit0 = 1, IDLE grants nothing that cycle (all readies 0) and arbitration state is unchanged.
  - Purpose: randomised but reproducible contention timing to stress the mutual exclusion between bakery instances.
- When undefined: no LFSR logic; grant occurs in the first eligible IDLE cycle.

Test Plan:
- Reset then read word 2 (araddr 0x008) -> rvalid one cycle after arready, rdata 0x0000_0000, rresp OKAY.
- Write 0xDEAD_BEEF to 0x008 with wstrb 4'hF, then write 0x0000_0011 with wstrb 4'b0001, then read 0x008 -> 0xDEAD_BE11, both bresp OKAY.
- Hold awvalid+wvalid and arvalid continuously from IDLE (last_served = READ) -> grants in order WRITE, READ, WRITE, READ.
- Write to 0x100 (index 64 = DEPTH) then read 0x100 -> bresp 10, rresp 10, rdata 0, words 0..63 unchanged.
- bready held 0 for 5 cycles after a write -> bvalid/bresp stable, awready/arready stay 0, with arvalid pending throughout; read served the cycle after bready rises.
- Assert reset while in RD_DATA with rready 0 -> rvalid drops immediately, memory reads back 0 after release.
